// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and datapath select values.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on mem_ready_i and are guarded by the timeout counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stall cycles of one memory access; flags the cycle in which the wait limit is reached.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The stalled cycle that would bring the count up to the limit is the timeout cycle.
  assign timeout = count && (cnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state-decoded datapath strobes, memory wait timeout, sticky error.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] Op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic       inst_done_o,
  output logic       error_o,
  output logic [3:0] state_o
);

  state_t state;
  logic   error_q;
  logic   wait_cnt_en;
  logic   wait_timeout;

  // Any cycle that is not a stalled memory cycle resets the count, so each access starts from zero.
  assign wait_cnt_en = is_mem_state(state) && !mem_ready_i;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (!wait_cnt_en),
    .count   (wait_cnt_en),
    .timeout (wait_timeout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (start_i) state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready_i) begin
            state <= S_DECODE;
          end else if (wait_timeout) begin
            state   <= S_HALT;
            error_q <= 1'b1;
          end
        end
        S_DECODE: begin
          case (Op_i)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_ADDI:      state <= S_ADDIEX;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default: begin
              state   <= S_HALT;
              error_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state <= (Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_ready_i) begin
            state <= S_MEMWB;
          end else if (wait_timeout) begin
            state   <= S_HALT;
            error_q <= 1'b1;
          end
        end
        S_MEMWR: begin
          if (mem_ready_i) begin
            state <= start_i ? S_FETCH : S_IDLE;
          end else if (wait_timeout) begin
            state   <= S_HALT;
            error_q <= 1'b1;
          end
        end
        S_EXEC:   state <= S_ALUWB;
        S_ADDIEX: state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
          state <= start_i ? S_FETCH : S_IDLE;
        S_HALT:   state <= S_HALT;
        default: begin
          state   <= S_HALT;
          error_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_REG;
    ALUOp_o       = ALUOP_ADD;
    PCSource_o    = PCSRC_ALU;
    inst_done_o   = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      S_DECODE: ALUSrcB_o = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite_o  = 1'b1;
        MemtoReg_o  = 1'b1;
        inst_done_o = 1'b1;
      end
      S_MEMWR: begin
        MemWrite_o  = 1'b1;
        IorD_o      = 1'b1;
        inst_done_o = mem_ready_i;
      end
      S_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite_o  = 1'b1;
        RegDst_o    = 1'b1;
        inst_done_o = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite_o  = 1'b1;
        inst_done_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = ALUOP_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = PCSRC_ALUOUT;
        inst_done_o   = 1'b1;
      end
      S_JUMP: begin
        PCWrite_o   = 1'b1;
        PCSource_o  = PCSRC_JUMP;
        inst_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign error_o = error_q;
  assign state_o = state;

endmodule
